// File: rtl/clock_field_editor.sv
// clock_field_editor: cursor-based editor for a multi-field HH:MM:SS style time value.
// While idle, set_time mirrors time_in. A rising set_mod enters edit mode, where the
// buttons move a digit cursor and step the selected field. Dropping set_mod commits
// the edit with a one-cycle commit pulse.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   set_mod                 - level request for edit mode (raw, synchronized here)
//   left, right, up, down   - raw button levels (synchronized here)
//   time_in  [6*FIELDS-1:0] - running time, field i at [6i+5:6i]
//   set_time [8*FIELDS-1:0] - edited time, field i at [8i+7:8i]
//   pos                     - cursor digit (2i = ones, 2i+1 = tens of field i)
//   editing, commit, blink  - edit-state flag, commit pulse, cursor blink phase
module clock_field_editor #(
    parameter int unsigned FIELDS        = 3,
    parameter int unsigned LIMIT         = 60,
    parameter int unsigned TOP_LIMIT     = 24,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned BLINK_CYCLES  = 50_000_000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          set_mod,
    input  logic                          left,
    input  logic                          right,
    input  logic                          up,
    input  logic                          down,
    input  logic [6*FIELDS-1:0]           time_in,
    output logic [8*FIELDS-1:0]           set_time,
    output logic [$clog2(2*FIELDS)-1:0]   pos,
    output logic                          editing,
    output logic                          commit,
    output logic                          blink
);
    localparam int unsigned TW      = 6;
    localparam int unsigned FW      = 8;
    localparam int unsigned NPOS    = 2 * FIELDS;
    localparam int unsigned PW      = $clog2(NPOS);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned BW      = $clog2(BLINK_CYCLES + 1);
    localparam int unsigned NB      = 5;
    // Synchronizer bit positions
    localparam int unsigned B_MOD = 0;
    localparam int unsigned B_LF  = 1;
    localparam int unsigned B_RT  = 2;
    localparam int unsigned B_UP  = 3;
    localparam int unsigned B_DN  = 4;

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t          state, state_n;
    logic [FW*FIELDS-1:0] set_time_n;
    logic [PW-1:0]   pos_n, sel;
    logic [BW-1:0]   blink_cnt, blink_cnt_n;
    logic            blink_n, editing_n, commit_n;
    logic [NB-1:0]   raw, sync1, sync2, sync2_d, rise;
    logic [1:0]      rep_fire;
    logic            ev_left, ev_right, ev_up, ev_dn, val_ev, cur_ev;

    // Field modulus: top field uses TOP_LIMIT, the rest LIMIT
    function automatic logic [FW-1:0] field_mod(input int idx);
        return (idx == int'(FIELDS) - 1) ? FW'(TOP_LIMIT) : FW'(LIMIT);
    endfunction

    // Modular +/-1 or +/-10 using a single compare/subtract (v is always < m)
    function automatic logic [FW-1:0] step_val(input logic [FW-1:0] v, input logic [FW-1:0] m,
                                               input logic tens, input logic inc);
        logic [FW-1:0] d;
        logic [FW-1:0] s;
        d = tens ? FW'(10) : FW'(1);
        s = v + d;
        if (inc)
            return (s >= m) ? s - m : s;
        return (v >= d) ? v - d : v + m - d;
    endfunction

    // Two-flop synchronizers plus a delayed copy for rising-edge detection
    assign raw = {down, up, right, left, set_mod};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end
    assign rise = sync2 & ~sync2_d;

    // Auto-repeat for up (g=0) and down (g=1): HOLD_CYCLES after the edge, then every REPEAT_CYCLES
    for (genvar g = 0; g < 2; g++) begin : g_rep
        logic [CW-1:0] cnt;
        logic          in_repeat;
        logic          lvl;
        logic          edge_ev;
        assign lvl     = sync2[B_UP + g];
        assign edge_ev = rise[B_UP + g];
        assign rep_fire[g] = lvl && !edge_ev &&
            (in_repeat ? (cnt == CW'(REPEAT_CYCLES - 1)) : (cnt == CW'(HOLD_CYCLES - 1)));
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt       <= '0;
                in_repeat <= 1'b0;
            end else if (!lvl || edge_ev) begin
                cnt       <= '0;
                in_repeat <= 1'b0;
            end else if (rep_fire[g]) begin
                cnt       <= '0;
                in_repeat <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign ev_left  = rise[B_LF];
    assign ev_right = rise[B_RT];
    assign ev_up    = rise[B_UP] | rep_fire[0];
    assign ev_dn    = rise[B_DN] | rep_fire[1];
    assign val_ev   = ev_up ^ ev_dn;      // simultaneous up+down cancels
    assign cur_ev   = ev_left ^ ev_right; // simultaneous left+right cancels
    assign sel      = pos >> 1;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            set_time  <= '0;
            pos       <= '0;
            blink     <= 1'b0;
            blink_cnt <= '0;
            editing   <= 1'b0;
            commit    <= 1'b0;
        end else begin
            state     <= state_n;
            set_time  <= set_time_n;
            pos       <= pos_n;
            blink     <= blink_n;
            blink_cnt <= blink_cnt_n;
            editing   <= editing_n;
            commit    <= commit_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        set_time_n  = set_time;
        pos_n       = pos;
        blink_n     = blink;
        blink_cnt_n = blink_cnt;
        case (state)
            IDLE: begin
                for (int i = 0; i < int'(FIELDS); i++) begin
                    set_time_n[i*FW +: FW] =
                        (FW'(time_in[i*TW +: TW]) >= field_mod(i)) ? '0 : FW'(time_in[i*TW +: TW]);
                end
                if (rise[B_MOD]) begin
                    state_n     = EDIT;
                    pos_n       = '0;
                    blink_n     = 1'b1;
                    blink_cnt_n = '0;
                end
            end
            EDIT: begin
                if (!sync2[B_MOD])
                    state_n = COMMIT;
                // Value update uses the pre-update cursor
                if (val_ev) begin
                    for (int i = 0; i < int'(FIELDS); i++) begin
                        if (sel == PW'(i))
                            set_time_n[i*FW +: FW] =
                                step_val(set_time[i*FW +: FW], field_mod(i), pos[0], ev_up);
                    end
                end
                if (cur_ev) begin
                    if (ev_left)
                        pos_n = (pos == PW'(NPOS - 1)) ? '0 : pos + PW'(1);
                    else
                        pos_n = (pos == '0) ? PW'(NPOS - 1) : pos - PW'(1);
                end
                if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                    blink_cnt_n = '0;
                    blink_n     = ~blink;
                end else begin
                    blink_cnt_n = blink_cnt + BW'(1);
                end
            end
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n != EDIT) begin
            blink_n     = 1'b0;
            blink_cnt_n = '0;
        end
        editing_n = (state_n == EDIT);
        commit_n  = (state_n == COMMIT);
    end
endmodule

// File: tb/tb_clock_field_editor.sv
// Bench for clock_field_editor: directed scenarios plus randomized button presses,
// all checked against a press-level arithmetic model of the editor.
module tb_clock_field_editor;
    localparam int FIELDS = 3;
    localparam int LIMIT  = 60;
    localparam int TOP    = 24;
    localparam int HOLD   = 8;
    localparam int REP    = 4;
    localparam int BLINK  = 5;
    localparam int NPOS   = 2 * FIELDS;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        set_mod, left, right, up, down;
    logic [17:0] time_in;
    logic [23:0] set_time;
    logic [2:0]  pos;
    logic        editing, commit, blink;

    int checks = 0;
    int errors = 0;
    int commit_cnt = 0;
    int m_time [FIELDS];
    int m_pos;
    bit m_edit;

    clock_field_editor #(
        .FIELDS(FIELDS), .LIMIT(LIMIT), .TOP_LIMIT(TOP),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .set_mod(set_mod),
        .left(left), .right(right), .up(up), .down(down),
        .time_in(time_in), .set_time(set_time), .pos(pos),
        .editing(editing), .commit(commit), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (commit === 1'b1) commit_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic int fmod(int i);
        return (i == FIELDS - 1) ? TOP : LIMIT;
    endfunction

    // Expected idle value of field i: raw time_in field, or 0 if out of range
    function automatic int fin(int i);
        int v;
        v = int'((time_in >> (6 * i)) & 18'h3f);
        return (v >= fmod(i)) ? 0 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < FIELDS; i++)
            chk($sformatf("%s_f%0d", tag, i), 32'(set_time[8*i +: 8]), m_edit ? m_time[i] : fin(i));
        chk($sformatf("%s_pos", tag), 32'(pos), m_pos);
        chk($sformatf("%s_editing", tag), 32'(editing), int'(m_edit));
    endtask

    // Model of one press: a held level produces events at offset 0, HOLD, HOLD+REP, ...
    // (up/down only); left/right act only at offset 0.
    task automatic model_press(input bit u, input bit d, input bit l, input bit r, input int hold);
        int f, m, st;
        if (!m_edit) return;
        for (int k = 0; k < hold; k++) begin
            if (!(k == 0 || (k >= HOLD && (k - HOLD) % REP == 0))) continue;
            if (u != d) begin
                f  = m_pos / 2;
                m  = fmod(f);
                st = (m_pos % 2) ? 10 : 1;
                m_time[f] = u ? (m_time[f] + st) % m : (m_time[f] - st + m) % m;
            end
            if (k == 0 && l != r)
                m_pos = l ? (m_pos + 1) % NPOS : (m_pos + NPOS - 1) % NPOS;
        end
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r, input int hold, input string tag);
        up = u; down = d; left = l; right = r;
        repeat (hold) @(negedge clk);
        up = 0; down = 0; left = 0; right = 0;
        repeat (6) @(negedge clk);
        model_press(u, d, l, r, hold);
        check_all(tag);
    endtask

    task automatic enter_edit(input string tag);
        int n;
        n = 0;
        set_mod = 1'b1;
        while (editing !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_enter", tag), 32'(editing), 1);
        m_edit = 1;
        m_pos  = 0;
        for (int i = 0; i < FIELDS; i++) m_time[i] = fin(i);
        chk($sformatf("%s_blink_start", tag), 32'(blink), 1);
        repeat (BLINK - 1) @(negedge clk);
        chk($sformatf("%s_blink_hold", tag), 32'(blink), 1);
        @(negedge clk);
        chk($sformatf("%s_blink_toggle", tag), 32'(blink), 0);
        check_all(tag);
    endtask

    initial begin
        int n, c0, mask, hold;
        set_mod = 0; left = 0; right = 0; up = 0; down = 0;
        time_in = {6'd12, 6'd34, 6'd56};
        m_pos = 0; m_edit = 0;
        for (int i = 0; i < FIELDS; i++) m_time[i] = 0;

        // Reset values
        #1 reset_n = 1'b0;
        #2;
        chk("rst_set_time", 32'(set_time), 0);
        chk("rst_pos", 32'(pos), 0);
        chk("rst_editing", 32'(editing), 0);
        chk("rst_commit", 32'(commit), 0);
        chk("rst_blink", 32'(blink), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all("idle_track");

        // Out-of-range fields load as zero
        time_in = {6'd25, 6'd59, 6'd60};
        repeat (2) @(negedge clk);
        chk("idle_sanitize", 32'(set_time), 32'h003B00);
        check_all("idle_sanitize_m");

        // Capture and cursor wrap
        time_in = {6'd12, 6'd34, 6'd56};
        @(negedge clk);
        enter_edit("enter1");
        chk("captured", 32'(set_time), 32'h0C2238);
        for (int i = 0; i < 7; i++) press(0, 0, 1, 0, 2, "left7");
        chk("pos_after_7_left", 32'(pos), 1);

        // Tens wrap on hours and seconds
        for (int i = 0; i < 4; i++) press(0, 0, 1, 0, 2, "to_pos5");
        press(1, 0, 0, 0, 2, "hr_up_tens");
        press(0, 0, 0, 1, 2, "to_pos4");
        press(1, 0, 0, 0, 2, "hr_up_ones");
        press(0, 0, 1, 0, 2, "back_pos5");
        chk("hours_23", 32'(set_time[23:16]), 23);
        press(1, 0, 0, 0, 2, "hr_up_wrap");
        chk("hours_9", 32'(set_time[23:16]), 9);
        press(0, 1, 0, 0, 2, "hr_down_wrap");
        chk("hours_back_23", 32'(set_time[23:16]), 23);
        press(0, 0, 1, 0, 2, "pos_wrap0");
        chk("pos_wrap_to0", 32'(pos), 0);
        for (int i = 0; i < 9; i++) press(1, 0, 0, 0, 2, "sec_up");
        press(0, 0, 1, 0, 2, "to_pos1");
        chk("sec_5", 32'(set_time[7:0]), 5);
        press(0, 1, 0, 0, 2, "sec_down_tens");
        chk("sec_55", 32'(set_time[7:0]), 55);

        // Auto-repeat from 58: events at offsets 0, 8, 12, 16, 20
        press(0, 0, 0, 1, 2, "to_pos0");
        for (int i = 0; i < 3; i++) press(1, 0, 0, 0, 2, "sec_to58");
        chk("sec_58", 32'(set_time[7:0]), 58);
        press(1, 0, 0, 0, 21, "auto_repeat");
        chk("sec_repeat_3", 32'(set_time[7:0]), 3);

        // Simultaneous events
        press(1, 1, 0, 0, 2, "up_down");
        chk("up_down_nochange", 32'(set_time[7:0]), 3);
        press(1, 0, 1, 0, 2, "up_left");
        chk("up_left_value", 32'(set_time[7:0]), 4);
        chk("up_left_pos", 32'(pos), 1);

        // Randomized presses, occasionally long enough to auto-repeat
        for (int it = 0; it < 40; it++) begin
            mask = int'($urandom_range(1, 15));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 18)) : int'($urandom_range(1, 3));
            press(mask[0], mask[1], mask[2], mask[3], hold, $sformatf("rand%0d", it));
        end

        // Commit: one pulse, set_time frozen during it, then tracking resumes
        c0 = commit_cnt;
        set_mod = 1'b0;
        n = 0;
        while (commit !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("commit_pulse", 32'(commit), 1);
        for (int i = 0; i < FIELDS; i++)
            chk($sformatf("commit_hold_f%0d", i), 32'(set_time[8*i +: 8]), m_time[i]);
        @(negedge clk);
        chk("commit_one_cycle", 32'(commit), 0);
        chk("commit_editing", 32'(editing), 0);
        m_edit = 0;
        time_in = {6'($urandom_range(0, 23)), 6'($urandom_range(0, 59)), 6'($urandom_range(0, 59))};
        repeat (2) @(negedge clk);
        check_all("track_after");
        chk("commit_count", 32'(commit_cnt - c0), 1);

        // Buttons ignored outside edit mode
        press(1, 0, 1, 0, 2, "idle_ignore");

        // Reset mid-edit discards the edit without a commit pulse
        time_in = {6'd23, 6'd34, 6'd56};
        @(negedge clk);
        enter_edit("enter2");
        press(0, 0, 0, 1, 2, "right_wrap5");
        chk("right_wrap_pos5", 32'(pos), 5);
        press(1, 0, 0, 0, 2, "hr_to9");
        chk("pre_reset_hours_9", 32'(set_time[23:16]), 9);
        c0 = commit_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_set_time", 32'(set_time), 0);
        chk("mid_rst_pos", 32'(pos), 0);
        chk("mid_rst_editing", 32'(editing), 0);
        chk("mid_rst_commit", 32'(commit), 0);
        chk("mid_rst_blink", 32'(blink), 0);
        set_mod = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_commit_after_reset", 32'(commit_cnt - c0), 0);
        m_edit = 0;
        m_pos  = 0;
        check_all("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
